// File: rtl/wb_pipe_pkg.sv
// Shared types and default parameters for the pipelined Wishbone slave
// front-end and its response pipeline.
package wb_pipe_pkg;

   localparam int unsigned DEF_DATA_W          = 32;
   localparam int unsigned DEF_ADDR_W          = 32;
   localparam int unsigned DEF_READ_LATENCY    = 1;
   localparam int unsigned DEF_MAX_OUTSTANDING = 4;

   // One response slot: valid marks a pending answer, err selects err over ack.
   typedef struct packed {
      logic valid;
      logic err;
   } stage_t;

endpackage : wb_pipe_pkg

// File: rtl/wb_pipe_interface_resp_pipe.sv
// Fixed-latency response shift register; a read tag travels alongside each
// slot so the top level knows whether to return memory data.
module wb_resp_pipe
   import wb_pipe_pkg::*;
#(
   parameter int unsigned LATENCY = DEF_READ_LATENCY
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   flush_i,
   input  stage_t in_i,
   input  logic   in_rd_i,
   output stage_t last_o,
   output logic   last_rd_o
);

   stage_t [LATENCY-1:0] stage_q, stage_d;
   logic   [LATENCY-1:0] rd_q, rd_d;

   generate
      if (LATENCY == 1) begin : g_one
         always_comb begin
            stage_d = in_i;
            rd_d    = in_rd_i;
            if (flush_i) begin
               stage_d = '0;
               rd_d    = '0;
            end
         end
      end else begin : g_multi
         always_comb begin
            stage_d = {stage_q[LATENCY-2:0], in_i};
            rd_d    = {rd_q[LATENCY-2:0], in_rd_i};
            if (flush_i) begin
               stage_d = '0;
               rd_d    = '0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= '0;
         rd_q    <= '0;
      end else begin
         stage_q <= stage_d;
         rd_q    <= rd_d;
      end
   end

   assign last_o    = stage_q[LATENCY-1];
   assign last_rd_o = rd_q[LATENCY-1];

endmodule : wb_resp_pipe

// File: rtl/wb_pipe_interface.sv
// Wishbone B4 pipelined slave bridging to a fixed-latency memory port, with
// address range checking and an outstanding-request limit.
module wb_pipe_interface
   import wb_pipe_pkg::*;
#(
   parameter int unsigned       DATA_W          = DEF_DATA_W,
   parameter int unsigned       ADDR_W          = DEF_ADDR_W,
   parameter int unsigned       READ_LATENCY    = DEF_READ_LATENCY,
   parameter int unsigned       MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT      = '1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_W-1:0]     wb_adr_i,
   input  logic [DATA_W-1:0]     wb_dat_i,
   input  logic                  wb_we_i,
   input  logic [DATA_W/8-1:0]   wb_sel_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_cyc_i,
   output logic [DATA_W-1:0]     wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_stall_o,
   output logic [ADDR_W-1:0]     addr_o,
   output logic                  read_o,
   output logic                  write_o,
   output logic [DATA_W-1:0]     write_data_o,
   output logic [DATA_W/8-1:0]   sel_o,
   input  logic [DATA_W-1:0]     read_data_i
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic             in_range_c;
   logic             accept_c;
   logic             resp_c;
   logic             last_rd_c;
   stage_t           stage_in_c;
   stage_t           last_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Stall comes only from the registered count, so a same-cycle retire never frees a slot early.
   assign wb_stall_o = rst_ni & (cnt_q == CNT_W'(MAX_OUTSTANDING));

   always_comb begin
      in_range_c       = (wb_adr_i <= ADDR_LIMIT);
      accept_c         = rst_ni & wb_cyc_i & wb_stb_i & ~wb_stall_o;
      stage_in_c.valid = accept_c;
      stage_in_c.err   = ~in_range_c;
   end

   assign read_o       = accept_c & in_range_c & ~wb_we_i;
   assign write_o      = accept_c & in_range_c & wb_we_i;
   assign addr_o       = wb_adr_i;
   assign write_data_o = wb_dat_i;
   assign sel_o        = wb_sel_i;

   wb_resp_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_resp_pipe (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (~wb_cyc_i),
      .in_i      (stage_in_c),
      .in_rd_i   (~wb_we_i),
      .last_o    (last_c),
      .last_rd_o (last_rd_c)
   );

   assign resp_c   = last_c.valid;
   assign wb_ack_o = last_c.valid & ~last_c.err & wb_cyc_i;
   assign wb_err_o = last_c.valid & last_c.err & wb_cyc_i;
   assign wb_dat_o = (wb_ack_o & last_rd_c) ? read_data_i : '0;

   // Outstanding count: dropping cyc abandons every pending response.
   always_comb begin
      cnt_d = cnt_q;
      if (!wb_cyc_i) begin
         cnt_d = '0;
      end else if (accept_c && !resp_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!accept_c && resp_c && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : wb_pipe_interface
